// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and helpers for the SRAM slave and its storage array.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE  = 3'd0,
    HSIZE_HALF  = 3'd1,
    HSIZE_WORD  = 3'd2,
    HSIZE_DWORD = 3'd3
  } hsize_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } slave_state_e;

  // Only the low byte of the address matters: the largest hsize is 128 bytes.
  function automatic logic size_aligned(input logic [7:0] addr_lo, input logic [2:0] size);
    logic [7:0] mask_s;
    mask_s = (8'd1 << size) - 8'd1;
    return (addr_lo & mask_s) == 8'd0;
  endfunction

endpackage

// File: rtl/ahb_sram_array.sv
// DEPTH x DW word storage with per-byte write enables, synchronous write and
// combinational read. Contents are deliberately not reset.
module ahb_sram_array #(
  parameter int DW    = 32,
  parameter int DEPTH = 1024,
  localparam int NB   = DW / 8,
  localparam int IW   = $clog2(DEPTH)
) (
  input  logic          hclk,
  input  logic [IW-1:0] waddr,
  input  logic [NB-1:0] wbe,
  input  logic [DW-1:0] wdata,
  input  logic [IW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_r [DEPTH];

  // byte-lane write port
  always_ff @(posedge hclk) begin
    for (int k = 0; k < NB; k++) begin
      if (wbe[k]) begin
        mem_r[waddr][8*k +: 8] <= wdata[8*k +: 8];
      end
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: programmable wait states, two-cycle ERROR response for
// forced, out-of-range, misaligned or oversized transfers.
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int RW          = 2,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic          hclk,
  input  logic          hresetn,
  input  logic [AW-1:0] haddr,
  input  logic [1:0]    htrans,
  input  logic          hwrite,
  input  logic [2:0]    hsize,
  input  logic [2:0]    hburst,
  input  logic [3:0]    hprot,
  input  logic [DW-1:0] hwdata,
  input  logic          error,
  output logic [DW-1:0] hrdata,
  output logic          hready,
  output logic [RW-1:0] hresp
);

  localparam int NB = DW / 8;
  localparam int BW = $clog2(NB);
  localparam int IW = $clog2(DEPTH);

  slave_state_e  state_r, state_n;
  logic [3:0]    cnt_r, cnt_n;
  logic [IW-1:0] idx_r;
  logic [BW-1:0] off_r;
  logic [2:0]    size_r;
  logic          write_r;

  logic          hready_s, resp_s, accept_s, err_s;
  logic          in_range_s, aligned_s, fits_s, we_s;
  logic [7:0]    nbytes_s;
  logic [NB-1:0] be_s;
  logic [DW-1:0] rdata_s;
  logic          unused_s;

  assign unused_s = ^{hburst, hprot};

  assign hready_s   = (state_r != ST_WAIT) && (state_r != ST_ERR1);
  assign resp_s     = (state_r == ST_ERR1) || (state_r == ST_ERR2);
  assign accept_s   = hready_s && ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));
  assign in_range_s = (haddr >> BW) < AW'(DEPTH);
  assign aligned_s  = size_aligned(haddr[7:0], hsize);
  assign fits_s     = hsize <= 3'(BW);
  assign err_s      = error || !in_range_s || !aligned_s || !fits_s;

  // next-state and wait-counter logic
  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    case (state_r)
      ST_IDLE, ST_DATA, ST_ERR2: begin
        if (!accept_s) begin
          state_n = ST_IDLE;
        end else if (err_s) begin
          state_n = ST_ERR1;
        end else if (WAIT_STATES > 0) begin
          state_n = ST_WAIT;
          cnt_n   = 4'(WAIT_STATES - 1);
        end else begin
          state_n = ST_DATA;
        end
      end
      ST_WAIT: begin
        if (cnt_r == 4'd0) begin
          state_n = ST_DATA;
        end else begin
          cnt_n = cnt_r - 4'd1;
        end
      end
      ST_ERR1: state_n = ST_ERR2;
      default: state_n = ST_IDLE;
    endcase
  end

  // state, wait counter and address/control latches
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      idx_r   <= '0;
      off_r   <= '0;
      size_r  <= 3'd0;
      write_r <= 1'b0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
      if (accept_s) begin
        idx_r   <= haddr[BW +: IW];
        off_r   <= haddr[BW-1:0];
        size_r  <= hsize;
        write_r <= hwrite;
      end
    end
  end

  assign we_s     = (state_r == ST_DATA) && write_r;
  assign nbytes_s = 8'd1 << size_r;

  // byte enables cover the 2**size lanes starting at the latched offset
  always_comb begin
    be_s = '0;
    for (int k = 0; k < NB; k++) begin
      if (we_s && (k >= int'(off_r)) && (k < int'(off_r) + int'(nbytes_s))) begin
        be_s[k] = 1'b1;
      end else begin
        be_s[k] = 1'b0;
      end
    end
  end

  ahb_sram_array #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_array (
    .hclk  (hclk),
    .waddr (idx_r),
    .wbe   (be_s),
    .wdata (hwdata),
    .raddr (idx_r),
    .rdata (rdata_s)
  );

  // read data is only driven in the DATA cycle of a read
  always_comb begin
    if ((state_r == ST_DATA) && !write_r) begin
      hrdata = rdata_s;
    end else begin
      hrdata = '0;
    end
  end

  assign hready = hready_s;
  assign hresp  = RW'(resp_s ? HRESP_ERROR : HRESP_OKAY);

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Randomized bench for ahb_sram_slave: two instances (0 and 3 wait states)
// checked cycle by cycle against a byte-array reference model.
module tb_ahb_sram_slave;

  localparam int DEPTH = 256;

  typedef struct packed {
    logic [1:0]  trans;
    logic        write;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic        err_force;
    logic        has_exp;
    logic [31:0] exp;
  } item_t;

  logic        hclk;
  logic [1:0]  hresetn;
  logic [31:0] haddr  [2];
  logic [1:0]  htrans [2];
  logic        hwrite [2];
  logic [2:0]  hsize  [2];
  logic [2:0]  hburst [2];
  logic [3:0]  hprot  [2];
  logic [31:0] hwdata [2];
  logic        error  [2];
  logic [31:0] hrdata [2];
  logic        hready [2];
  logic [1:0]  hresp  [2];

  logic [7:0]  mem_m [2][DEPTH*4];
  item_t       q[$];
  int          n_checks = 0;
  int          n_errors = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    ahb_sram_slave #(
      .AW(32), .DW(32), .RW(2), .DEPTH(DEPTH), .WAIT_STATES(g * 3)
    ) u_dut (
      .hclk(hclk), .hresetn(hresetn[g]), .haddr(haddr[g]), .htrans(htrans[g]),
      .hwrite(hwrite[g]), .hsize(hsize[g]), .hburst(hburst[g]), .hprot(hprot[g]),
      .hwdata(hwdata[g]), .error(error[g]), .hrdata(hrdata[g]), .hready(hready[g]),
      .hresp(hresp[g])
    );
  end

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  function automatic item_t mk(input logic [1:0] trans, input logic write, input logic [31:0] addr,
                               input logic [2:0] size, input logic [31:0] wdata, input logic errf);
    item_t it;
    it = '0;
    it.trans = trans; it.write = write; it.addr = addr; it.size = size;
    it.wdata = wdata; it.err_force = errf;
    return it;
  endfunction

  function automatic item_t mk_exp(input logic [31:0] addr, input logic [31:0] exp);
    item_t it;
    it = mk(2'd2, 1'b0, addr, 3'd2, 32'd0, 1'b0);
    it.has_exp = 1'b1;
    it.exp = exp;
    return it;
  endfunction

  // reference rules: forced, beyond DEPTH words, misaligned, or wider than the bus
  function automatic logic model_err(input item_t it);
    int unsigned nb;
    nb = 32'd1 << it.size;
    return it.err_force || ((it.addr / 4) >= DEPTH) || ((it.addr % nb) != 0) || (nb > 4);
  endfunction

  function automatic logic [31:0] model_read(input int d, input logic [31:0] addr);
    int unsigned w;
    w = (addr / 4) * 4;
    return {mem_m[d][w+3], mem_m[d][w+2], mem_m[d][w+1], mem_m[d][w]};
  endfunction

  task automatic model_write(input int d, input item_t it);
    int unsigned a;
    for (int b = 0; b < (1 << it.size); b++) begin
      a = it.addr + b;
      mem_m[d][a] = it.wdata[8*(a%4) +: 8];
    end
  endtask

  task automatic drive(input int d, input item_t it);
    haddr[d]  = it.addr;
    htrans[d] = it.trans;
    hwrite[d] = it.write;
    hsize[d]  = it.size;
    hburst[d] = 3'($urandom);
    hprot[d]  = 4'($urandom);
    error[d]  = it.err_force;
  endtask

  function automatic item_t rand_item();
    item_t it;
    int r, sz;
    r  = $urandom_range(0, 19);
    sz = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
    it = mk((r < 2) ? 2'd0 : (r < 4) ? 2'd1 : (r < 12) ? 2'd2 : 2'd3, 1'($urandom),
            32'($urandom_range(0, 127)) & ~(32'd1 << sz) + 32'd1 & ~((32'd1 << sz) - 32'd1),
            3'(sz), $urandom, ($urandom_range(0, 15) == 0));
    r = $urandom_range(0, 9);
    if (r == 0 && sz > 0) it.addr = it.addr | 32'd1;
    else if (r == 1) it.addr = 32'(DEPTH * 4) + 32'($urandom_range(0, 255));
    else if (r == 2) it.addr = 32'h8000_0000 | (it.addr & 32'h7f);
    return it;
  endfunction

  // issue the queue on DUT d as a pipelined master, checking every data-phase cycle
  task automatic run_queue(input int d);
    item_t cur, it;
    int cyc, budget, ws, last;
    logic err;
    logic [31:0] exp_rd;
    cur = '0; cyc = 0; budget = 0; ws = d * 3;
    while ((q.size() > 0 || cur.trans[1]) && budget < 4000) begin
      @(negedge hclk);
      budget++;
      hwdata[d] = (cur.trans[1] && cur.write) ? cur.wdata : $urandom;
      if (cur.trans[1]) begin
        cyc++;
        err    = model_err(cur);
        last   = err ? 2 : ws + 1;
        exp_rd = (!err && !cur.write && cyc == last) ? model_read(d, cur.addr) : 32'd0;
        check_eq($sformatf("d%0d_hready@%h", d, cur.addr), 32'(hready[d]), 32'(cyc == last));
        check_eq($sformatf("d%0d_hresp@%h", d, cur.addr), 32'(hresp[d]), 32'(err));
        check_eq($sformatf("d%0d_hrdata@%h", d, cur.addr), hrdata[d], exp_rd);
        if (hready[d]) begin
          if (cur.has_exp) check_eq($sformatf("d%0d_dir_rd@%h", d, cur.addr), hrdata[d], cur.exp);
          if (!err && cur.write) model_write(d, cur);
        end
      end else begin
        check_eq($sformatf("d%0d_idle_hready", d), 32'(hready[d]), 32'd1);
        check_eq($sformatf("d%0d_idle_hresp", d), 32'(hresp[d]), 32'd0);
        check_eq($sformatf("d%0d_idle_hrdata", d), hrdata[d], 32'd0);
      end
      if (hready[d]) begin
        it = (q.size() > 0) ? q.pop_front() : item_t'('0);
        drive(d, it);
        cur = it;
        cyc = 0;
      end
    end
    drive(d, item_t'('0));
    check_eq($sformatf("d%0d_timeout", d), 32'(budget < 4000), 32'd1);
  endtask

  task automatic push_directed(input int d);
    for (int w = 0; w < 32; w++) q.push_back(mk(2'd2, 1'b1, 32'(w * 4), 3'd2, $urandom, 1'b0));
    q.push_back(mk(2'd2, 1'b1, 32'h10, 3'd2, 32'hDEADBEEF, 1'b0));
    q.push_back(mk_exp(32'h10, 32'hDEADBEEF));
    q.push_back(mk(2'd2, 1'b1, 32'h13, 3'd0, 32'hAA000000, 1'b0));
    q.push_back(mk_exp(32'h10, 32'hAAADBEEF));
    q.push_back(mk(2'd3, 1'b0, 32'h20, 3'd2, 32'd0, 1'b0));
    q.push_back(mk(2'd2, 1'b1, 32'h22, 3'd2, 32'h5555AAAA, 1'b0));
    q.push_back(mk(2'd2, 1'b0, 32'h20, 3'd2, 32'd0, 1'b0));
    q.push_back(mk(2'd2, 1'b1, 32'h30, 3'd2, 32'h0BADF00D, 1'b1));
    q.push_back(mk(2'd2, 1'b0, 32'(DEPTH * 4), 3'd2, 32'd0, 1'b0));
    q.push_back(mk(2'd2, 1'b0, 32'h30, 3'd2, 32'd0, 1'b0));
    q.push_back(mk(2'd1, 1'b1, 32'h40, 3'd2, 32'd0, 1'b1));
    q.push_back(mk(2'd2, 1'b0, 32'h30, 3'd2, 32'd0, 1'b0));
    for (int i = 0; i < 80; i++) q.push_back(rand_item());
    if (d > 1) $display("unexpected instance %0d", d);
  endtask

  initial begin
    hresetn = 2'b00;
    for (int d = 0; d < 2; d++) begin
      drive(d, item_t'('0));
      hwdata[d] = 32'd0;
    end
    repeat (3) @(negedge hclk);
    for (int d = 0; d < 2; d++) begin
      check_eq($sformatf("d%0d_rst_hready", d), 32'(hready[d]), 32'd1);
      check_eq($sformatf("d%0d_rst_hresp", d), 32'(hresp[d]), 32'd0);
      check_eq($sformatf("d%0d_rst_hrdata", d), hrdata[d], 32'd0);
    end
    hresetn = 2'b11;

    for (int d = 0; d < 2; d++) begin
      push_directed(d);
      run_queue(d);
    end

    // reset in the middle of a waited write on the 3-wait-state instance
    @(negedge hclk);
    drive(1, mk(2'd2, 1'b1, 32'h20, 3'd2, 32'd0, 1'b0));
    @(negedge hclk);
    drive(1, item_t'('0));
    hwdata[1] = 32'h12345678;
    check_eq("d1_wait_hready", 32'(hready[1]), 32'd0);
    @(negedge hclk);
    check_eq("d1_wait2_hready", 32'(hready[1]), 32'd0);
    hresetn[1] = 1'b0;
    #1;
    check_eq("d1_midrst_hready", 32'(hready[1]), 32'd1);
    check_eq("d1_midrst_hresp", 32'(hresp[1]), 32'd0);
    check_eq("d1_midrst_hrdata", hrdata[1], 32'd0);
    @(negedge hclk);
    hresetn[1] = 1'b1;
    q.push_back(mk_exp(32'h20, model_read(1, 32'h20)));
    run_queue(1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
